// File: rtl/aes_inv_key_schedule_if.sv
// Handshake/bus bundle between the inverse-cipher controller and the
// reverse-order AES-128 round-key source.
interface aes_inv_key_schedule_if;
    logic         kenable;
    logic [127:0] key;
    logic         kstep;
    logic [31:0]  wo_0;
    logic [31:0]  wo_1;
    logic [31:0]  wo_2;
    logic [31:0]  wo_3;
    logic [3:0]   round_idx;
    logic         rkey_valid;
    logic         busy;
    logic         done;

    // Controller side: loads keys and requests steps.
    modport master (
        output kenable, key, kstep,
        input  wo_0, wo_1, wo_2, wo_3, round_idx, rkey_valid, busy, done
    );

    // Key-schedule side.
    modport slave (
        input  kenable, key, kstep,
        output wo_0, wo_1, wo_2, wo_3, round_idx, rkey_valid, busy, done
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Reverse-order AES-128 round-key source. A load runs the forward expansion
// for 10 cycles to reach the round-10 key, then each kstep walks one round
// back toward the cipher key. One combinational step per clock.

// Forward AES S-box, one byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = TABLE[a];
endmodule

module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_inv_key_schedule_if.slave  bus
);
    // Only the AES-128 schedule is implemented.
    if (NR != 10) begin : g_bad_nr
        $error("aes_inv_key_schedule: only NR=10 is supported");
    end

    typedef enum logic [1:0] {IDLE, FWD, REV, DONE} state_t;

    state_t           state;
    logic [3:0][31:0] w;
    logic [3:0]       fcnt;
    logic [3:0]       round_idx;
    logic             rkey_valid;
    logic             busy;
    logic             done;

    logic [31:0] inv_w3;
    logic [31:0] sb_src;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [3:0]  rc_sel;
    logic [31:0] t;
    logic [3:0][31:0] w_fwd;
    logic [3:0][31:0] w_inv;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // The S-boxes are shared: forward steps feed w3, inverse steps feed the
    // recomputed previous-round w3 (w3 ^ w2).
    assign inv_w3 = w[3] ^ w[2];
    assign sb_src = (state == REV) ? inv_w3 : w[3];
    assign rot    = {sb_src[23:0], sb_src[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    // Forward uses the ascending counter, reverse the descending round index.
    assign rc_sel = (state == REV) ? round_idx : fcnt;
    assign t      = sub ^ {rcon(rc_sel), 24'h0};

    // Next-state words for a forward and an inverse step.
    always_comb begin
        w_fwd    = w;
        w_inv    = w;
        w_fwd[0] = w[0] ^ t;
        w_fwd[1] = w[1] ^ w_fwd[0];
        w_fwd[2] = w[2] ^ w_fwd[1];
        w_fwd[3] = w[3] ^ w_fwd[2];
        w_inv[3] = inv_w3;
        w_inv[2] = w[2] ^ w[1];
        w_inv[1] = w[1] ^ w[0];
        w_inv[0] = w[0] ^ t;
    end

    // Schedule FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            w          <= '0;
            fcnt       <= '0;
            round_idx  <= '0;
            rkey_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (bus.kenable) begin
            w[0]       <= bus.key[127:96];
            w[1]       <= bus.key[95:64];
            w[2]       <= bus.key[63:32];
            w[3]       <= bus.key[31:0];
            fcnt       <= 4'd1;
            state      <= FWD;
            busy       <= 1'b1;
            rkey_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                FWD: begin
                    w    <= w_fwd;
                    fcnt <= fcnt + 4'd1;
                    if (fcnt == 4'd10) begin
                        state      <= REV;
                        round_idx  <= 4'd10;
                        rkey_valid <= 1'b1;
                    end
                end
                REV: begin
                    if (bus.kstep) begin
                        if (round_idx != 4'd0) begin
                            w         <= w_inv;
                            round_idx <= round_idx - 4'd1;
                        end else begin
                            state      <= DONE;
                            rkey_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wo_0       = w[0];
    assign bus.wo_1       = w[1];
    assign bus.wo_2       = w[2];
    assign bus.wo_3       = w[3];
    assign bus.round_idx  = round_idx;
    assign bus.rkey_valid = rkey_valid;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule
